// File: rtl/stack_if.sv
// Stack operation bus: opcode strobe and operand from the decoder, stack
// status (TOS/NOS, occupancy, error flags, high-water mark) back to it.
interface stack_if #(
   parameter int DW = 32,
   parameter int AW = 8
);
   logic          op_valid;
   logic [2:0]    op;
   logic [DW-1:0] din;
   logic          err_clr;
   logic          hwm_clr;
   logic [DW-1:0] tos;
   logic [DW-1:0] nos;
   logic [AW:0]   depth;
   logic          empty;
   logic          full;
   logic          ovf;
   logic          unf;
   logic [AW:0]   hwm;

   modport master (
      output op_valid, op, din, err_clr, hwm_clr,
      input  tos, nos, depth, empty, full, ovf, unf, hwm
   );

   modport slave (
      input  op_valid, op, din, err_clr, hwm_clr,
      output tos, nos, depth, empty, full, ovf, unf, hwm
   );
endinterface

// File: rtl/stack_engine.sv
// Parametrised data/return stack: TOS/NOS registers plus a synchronous RAM
// holding entries 3..n. One op per cycle, guarded against over/underflow.
// Optional macro STACK_HWM_EN adds a high-water mark of the occupancy.
module stack_engine #(
   parameter int DW    = 32,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input logic    clk,
   input logic    rst,
   stack_if.slave bus
);
   localparam logic [2:0] OP_PUSH    = 3'd0;
   localparam logic [2:0] OP_DROP    = 3'd1;
   localparam logic [2:0] OP_SWAP    = 3'd2;
   localparam logic [2:0] OP_DUP     = 3'd3;
   localparam logic [2:0] OP_OVER    = 3'd4;
   localparam logic [2:0] OP_ROT     = 3'd5;
   localparam logic [2:0] OP_REPLACE = 3'd6;

   localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE     = (AW+1)'(1);
   localparam logic [AW:0] TWO     = (AW+1)'(2);
   localparam logic [AW:0] THREE   = (AW+1)'(3);

   logic [DW-1:0] tos_q, tos_d, nos_q, nos_d, third_q;
   logic [AW:0]   depth_q, depth_d, need;
   logic [AW-1:0] sp_q, sp_d, wa;
   logic          ovf_q, ovf_d, unf_q, unf_d;
   logic          ovf_err, unf_err, exec, we, grow;
   logic [DW-1:0] mem [DEPTH];

   // Guard check, then next TOS/NOS/depth/sp and RAM write for the current op.
   always_comb begin
      grow = 1'b0;
      need = '0;
      case (bus.op)
         OP_PUSH:    grow = 1'b1;
         OP_DROP:    need = ONE;
         OP_SWAP:    need = TWO;
         OP_DUP:     begin grow = 1'b1; need = ONE; end
         OP_OVER:    begin grow = 1'b1; need = TWO; end
         OP_ROT:     need = THREE;
         OP_REPLACE: need = ONE;
         default:    need = TWO;
      endcase
      ovf_err = bus.op_valid && grow && (depth_q == DEPTH_V);
      unf_err = bus.op_valid && (depth_q < need);
      exec    = bus.op_valid && !ovf_err && !unf_err;

      tos_d   = tos_q;
      nos_d   = nos_q;
      depth_d = depth_q;
      we      = 1'b0;
      wa      = sp_q + AW'(1);
      if (exec) begin
         case (bus.op)
            OP_PUSH: begin
               tos_d = bus.din; nos_d = tos_q; we = 1'b1; depth_d = depth_q + ONE;
            end
            OP_DROP: begin
               tos_d = nos_q; nos_d = third_q; depth_d = depth_q - ONE;
            end
            OP_SWAP: begin
               tos_d = nos_q; nos_d = tos_q;
            end
            OP_DUP: begin
               nos_d = tos_q; we = 1'b1; depth_d = depth_q + ONE;
            end
            OP_OVER: begin
               tos_d = nos_q; nos_d = tos_q; we = 1'b1; depth_d = depth_q + ONE;
            end
            OP_ROT: begin
               // a b c -> c a b: old NOS sinks into the third slot in place
               tos_d = third_q; nos_d = tos_q; we = 1'b1; wa = sp_q;
            end
            OP_REPLACE: begin
               tos_d = bus.din;
            end
            default: begin
               tos_d = bus.din; nos_d = third_q; depth_d = depth_q - ONE;
            end
         endcase
      end
      // sp points at the third entry; it parks at 0 while only TOS/NOS are live
      sp_d = (depth_d >= THREE) ? AW'(depth_d - TWO) : '0;

      // a fresh error beats a coincident clear
      ovf_d = bus.err_clr ? 1'b0 : ovf_q;
      unf_d = bus.err_clr ? 1'b0 : unf_q;
      if (ovf_err) ovf_d = 1'b1;
      if (unf_err) unf_d = 1'b1;
   end

   // Control and TOS/NOS state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         tos_q   <= '0;
         nos_q   <= '0;
         depth_q <= '0;
         sp_q    <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         tos_q   <= tos_d;
         nos_q   <= nos_d;
         depth_q <= depth_d;
         sp_q    <= sp_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Write-first RAM read at the next sp, so the third entry is valid after every op.
   always_ff @(posedge clk) begin
      if (we && !rst) mem[wa] <= nos_q;
      if (we && !rst && (wa == sp_d)) third_q <= nos_q;
      else                            third_q <= mem[sp_d];
   end

   assign bus.tos   = tos_q;
   assign bus.nos   = nos_q;
   assign bus.depth = depth_q;
   assign bus.empty = (depth_q == '0);
   assign bus.full  = (depth_q == DEPTH_V);
   assign bus.ovf   = ovf_q;
   assign bus.unf   = unf_q;

`ifdef STACK_HWM_EN
   logic [AW:0] hwm_q, hwm_d;

   // Track peak occupancy; a clear restarts from the occupancy after this op.
   always_comb begin
      hwm_d = hwm_q;
      if (bus.hwm_clr)          hwm_d = depth_d;
      else if (depth_d > hwm_q) hwm_d = depth_d;
   end

   // High-water mark register.
   always_ff @(posedge clk) begin
      if (rst) hwm_q <= '0;
      else     hwm_q <= hwm_d;
   end

   assign bus.hwm = hwm_q;
`else
   logic unused_hwm_clr;
   assign unused_hwm_clr = bus.hwm_clr;
   assign bus.hwm        = '0;
`endif
endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine (DW=32, DEPTH=4): a logical-stack reference model
// queues the expected status for each op; each scenario pops and compares.
module tb_stack_engine;
   localparam int DW = 32;
   localparam int DEPTH = 4;
   localparam int AW = 2;

   localparam logic [2:0] PUSH = 3'd0, DROP = 3'd1, SWAP = 3'd2, DUP = 3'd3;
   localparam logic [2:0] OVER = 3'd4, ROT = 3'd5, REPLACE = 3'd6, REDUCE = 3'd7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stack_if #(.DW(DW), .AW(AW)) bus ();

   stack_engine #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // observed vector: tos[73:42] nos[41:10] depth[9:7] empty[6] full[5] ovf[4] unf[3] hwm[2:0]
   typedef struct {
      logic [73:0] v;
      logic [73:0] m;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad = 0;

   logic [31:0] mstk [4];
   int md;
   bit movf, munf;
   int mhwm;

   function automatic logic [73:0] obs();
      return {bus.tos, bus.nos, bus.depth, bus.empty, bus.full, bus.ovf, bus.unf, bus.hwm};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.op_valid = 1'b1;       // rst must override a pending op
      bus.op = PUSH;
      bus.din = 32'hDEAD_BEEF;
      bus.err_clr = 1'b0;
      bus.hwm_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.op_valid = 1'b0;
      md = 0; movf = 0; munf = 0; mhwm = 0;
      sb.delete();
   endtask

   // Drive one op for one cycle and queue the model's expected status.
   task automatic issue(input bit v, input logic [2:0] o, input logic [31:0] d,
                        input bit ec, input bit hc);
      int need;
      bit oe, ue;
      exp_t e;
      logic [31:0] a, b, c;
      bus.op_valid = v; bus.op = o; bus.din = d; bus.err_clr = ec; bus.hwm_clr = hc;
      oe = 0; ue = 0;
      if (v) begin
         case (o)
            PUSH, DUP, OVER: oe = (md == DEPTH);
            default: oe = 0;
         endcase
         case (o)
            DROP, DUP, REPLACE: need = 1;
            SWAP, OVER, REDUCE: need = 2;
            ROT: need = 3;
            default: need = 0;
         endcase
         ue = (md < need);
         if (!oe && !ue) begin
            case (o)
               PUSH: begin mstk[md] = d; md++; end
               DROP: md--;
               SWAP: begin a = mstk[md-1]; mstk[md-1] = mstk[md-2]; mstk[md-2] = a; end
               DUP: begin mstk[md] = mstk[md-1]; md++; end
               OVER: begin mstk[md] = mstk[md-2]; md++; end
               ROT: begin
                  a = mstk[md-1]; b = mstk[md-2]; c = mstk[md-3];
                  mstk[md-1] = c; mstk[md-2] = a; mstk[md-3] = b;
               end
               REPLACE: mstk[md-1] = d;
               default: begin mstk[md-2] = d; md--; end
            endcase
         end
      end
      if (ec) begin movf = 0; munf = 0; end
      if (oe) movf = 1;
      if (ue) munf = 1;
`ifdef STACK_HWM_EN
      if (hc) mhwm = md;
      else if (md > mhwm) mhwm = md;
`endif
      e.v = '0; e.m = '0;
      e.v[9:7] = md[2:0];
      e.v[6] = (md == 0);
      e.v[5] = (md == DEPTH);
      e.v[4] = movf;
      e.v[3] = munf;
      e.v[2:0] = mhwm[2:0];
      e.m[9:0] = '1;
      if (md >= 1) begin e.v[73:42] = mstk[md-1]; e.m[73:42] = '1; end
      if (md >= 2) begin e.v[41:10] = mstk[md-2]; e.m[41:10] = '1; end
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0; bus.err_clr = 1'b0; bus.hwm_clr = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      do_reset();
      issue(1, DROP, 0, 0, 0);
      e = sb.pop_front();
      total++;
      if ((obs() & e.m) !== (e.v & e.m)) begin
         bad++;
         $display("FAIL reset_unf: got %h want %h", obs() & e.m, e.v & e.m);
      end
      do_reset();
      total++;
      if (obs() !== 74'h40) begin
         bad++;
         $display("FAIL reset_state: got %h want %h", obs(), 74'h40);
      end
   endtask

   task automatic test_push_drop();
      int ops [5] = '{0, 0, 0, 1, 1};
      int dins [5] = '{32'h11, 32'h22, 32'h33, 0, 0};
      exp_t e;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         issue(1, 3'(ops[i]), 32'(dins[i]), 0, 0);
         e = sb.pop_front();
         total++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL push_drop step %0d: got %h want %h", i, obs() & e.m, e.v & e.m);
         end
      end
   endtask

   task automatic test_rot();
      int ops [6] = '{0, 0, 0, 5, 1, 1};
      int dins [6] = '{1, 2, 3, 0, 0, 0};
      exp_t e;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         issue(1, 3'(ops[i]), 32'(dins[i]), 0, 0);
         e = sb.pop_front();
         total++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL rot step %0d: got %h want %h", i, obs() & e.m, e.v & e.m);
         end
      end
   endtask

   task automatic test_overflow();
      int vs [7] = '{1, 1, 1, 1, 1, 0, 1};
      int dins [7] = '{1, 2, 3, 4, 5, 0, 6};
      int ecs [7] = '{0, 0, 0, 0, 0, 1, 1};
      exp_t e;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         issue(vs[i] != 0, PUSH, 32'(dins[i]), ecs[i] != 0, 0);
         e = sb.pop_front();
         total++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL overflow step %0d: got %h want %h", i, obs() & e.m, e.v & e.m);
         end
      end
   endtask

   task automatic test_underflow();
      int ops [5] = '{1, 0, 2, 0, 5};
      int dins [5] = '{0, 7, 0, 8, 0};
      exp_t e;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         issue(1, 3'(ops[i]), 32'(dins[i]), 0, 0);
         e = sb.pop_front();
         total++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL underflow step %0d: got %h want %h", i, obs() & e.m, e.v & e.m);
         end
      end
   endtask

   task automatic test_reduce_ops();
      int ops [8] = '{0, 0, 7, 3, 0, 4, 2, 6};
      int dins [8] = '{5, 6, 32'hB, 0, 9, 0, 0, 32'h77};
      exp_t e;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         issue(1, 3'(ops[i]), 32'(dins[i]), 0, 0);
         e = sb.pop_front();
         total++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL reduce_ops step %0d: got %h want %h", i, obs() & e.m, e.v & e.m);
         end
      end
   endtask

   task automatic test_hwm();
      int vs [7] = '{1, 1, 1, 1, 1, 0, 1};
      int ops [7] = '{0, 0, 0, 1, 1, 0, 0};
      int hcs [7] = '{0, 0, 0, 0, 0, 1, 1};
      exp_t e;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         issue(vs[i] != 0, 3'(ops[i]), 32'(i + 100), 0, hcs[i] != 0);
         e = sb.pop_front();
         total++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL hwm step %0d: got %h want %h", i, obs() & e.m, e.v & e.m);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [2:0] o;
      do_reset();
      for (int i = 0; i < 200; i++) begin
         if (i < 100) o = ($urandom_range(0, 1) == 0) ? PUSH : DROP;
         else         o = 3'($urandom_range(0, 7));
         issue(1, o, $urandom, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
         e = sb.pop_front();
         total++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL back_to_back cycle %0d op %0d: got %h want %h", i, o, obs() & e.m, e.v & e.m);
         end
      end
   endtask

   initial begin
      bus.op_valid = 1'b0;
      bus.op = PUSH;
      bus.din = '0;
      bus.err_clr = 1'b0;
      bus.hwm_clr = 1'b0;
      test_reset();
      test_push_drop();
      test_rot();
      test_overflow();
      test_underflow();
      test_reduce_ops();
      test_hwm();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
